// File: rtl/fill_memory_responder.sv
// Fixed-latency word memory responder: writes commit at the accepting edge, reads
// return through a LATENCY-deep valid/data shift pipeline with no back-pressure.
module fill_memory_responder #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       data_in,
  output logic [15:0]       data_out,
  output logic              data_valid,
  output logic [3:0]        outstanding
);

  localparam int unsigned Words = 2 ** (ADDR_W - 1);

  logic [15:0]       mem [Words];
  logic [ADDR_W-2:0] word;
  logic              rd_acc;
  logic              wr_acc;

  logic [LATENCY-1:0] vld_q;
  logic [15:0]        dat_q [LATENCY];
  logic [3:0]         cnt_q;

  assign word   = addr[ADDR_W-1:1];
  assign rd_acc = enable & ~wr;
  assign wr_acc = enable & wr & ~rst;

  // Storage is never cleared by rst; a write presented while rst is high is dropped.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[word] <= data_in;
    end
  end

  // Data stages carry zero on empty slots so data_out is 0 whenever data_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= 16'h0000;
      end
      cnt_q <= 4'd0;
    end else begin
      vld_q[0] <= rd_acc;
      dat_q[0] <= rd_acc ? mem[word] : 16'h0000;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
      unique case ({rd_acc, vld_q[LATENCY-1]})
        2'b10:   cnt_q <= cnt_q + 4'd1;
        2'b01:   cnt_q <= cnt_q - 4'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign data_valid  = vld_q[LATENCY-1];
  assign data_out    = dat_q[LATENCY-1];
  assign outstanding = cnt_q;

  // Every accepted read leaves the pipe after LATENCY edges, so the count is bounded.
  a_cnt_bound : assert property (@(posedge clk) disable iff (rst) cnt_q <= 4'(LATENCY));

endmodule

// File: tb/tb_fill_memory_responder.sv
// Bench for fill_memory_responder: directed table, hand-written corner sequences and
// randomized traffic, all checked against an edge-indexed reference model.
module tb_fill_memory_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] data_in = 16'h0000;
  logic [15:0] data_out;
  logic        data_valid;
  logic [3:0]  outstanding;

  fill_memory_responder #(
    .LATENCY(LAT),
    .ADDR_W (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int max_out = 0;

  // Model: word contents, and read data keyed by the edge after which it is visible.
  logic [15:0] mem_m [int];
  logic [15:0] exp_d [int];

  typedef struct {
    logic        en;
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic        ev;
    logic [15:0] ed;
    logic [3:0]  eo;
  } vec_t;

  vec_t tbl [10];

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, expv);
    end
  endtask

  task automatic check_model(input string tag);
    logic        ev;
    logic [15:0] ed;
    int          eo;
    ev = exp_d.exists(edge_n);
    ed = ev ? exp_d[edge_n] : 16'h0000;
    eo = 0;
    foreach (exp_d[k]) begin
      if (k >= edge_n && k <= edge_n + LAT - 1) eo++;
    end
    cmp({tag, "_valid"}, {15'd0, data_valid}, {15'd0, ev});
    cmp({tag, "_data"}, data_out, ed);
    cmp({tag, "_outstanding"}, {12'd0, outstanding}, 16'(eo));
    if (int'(outstanding) > max_out) max_out = int'(outstanding);
  endtask

  // Apply one request for one clock; inputs change at the falling edge only.
  task automatic drive(input string tag, input logic en, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
    @(posedge clk);
    edge_n++;
    if (!rst && en) begin
      if (w) mem_m[int'(a[15:1])] = d;
      else   exp_d[edge_n + LAT - 1] = mem_m[int'(a[15:1])];
    end
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) drive(tag, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 16'h0040, 16'h1234, 1'b0, 16'h0000, 4'd0};
    tbl[1] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000, 4'd1};
    tbl[2] = '{1'b1, 1'b0, 16'h0041, 16'h0000, 1'b0, 16'h0000, 4'd2};
    tbl[3] = '{1'b1, 1'b0, 16'h0080, 16'h0000, 1'b0, 16'h0000, 4'd3};
    tbl[4] = '{1'b1, 1'b1, 16'h0080, 16'hBEEF, 1'b1, 16'h1234, 4'd3};
    tbl[5] = '{1'b1, 1'b0, 16'h0080, 16'h0000, 1'b1, 16'h1234, 4'd3};
    tbl[6] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h5555, 4'd2};
    tbl[7] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd1};
    tbl[8] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 4'd1};
    tbl[9] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd0};

    // Reset state.
    idle("reset", 2);
    rst = 1'b0;

    // Preload working regions through the write port.
    for (int i = 0; i < 8; i++) drive("pre_a", 1'b1, 1'b1, 16'(16'h0100 + 2 * i), 16'(16'hA000 + i));
    for (int i = 0; i < 32; i++) drive("pre_r", 1'b1, 1'b1, 16'(16'h0200 + 2 * i), 16'($urandom));
    drive("pre_80", 1'b1, 1'b1, 16'h0080, 16'h5555);
    idle("pre_idle", LAT);

    // Eight back-to-back reads stream out in order with a peak count of LATENCY.
    max_out = 0;
    for (int i = 0; i < 8; i++) drive("burst", 1'b1, 1'b0, 16'(16'h0100 + 2 * i), 16'h0000);
    idle("burst_drain", LAT + 1);
    cmp("burst_peak", 16'(max_out), 16'd4);

    // Read-after-write, addr[0] ignored, write-after-read.
    for (int i = 0; i < 10; i++) begin
      drive("tbl_model", tbl[i].en, tbl[i].w, tbl[i].a, tbl[i].d);
      cmp($sformatf("tbl%0d_valid", i), {15'd0, data_valid}, {15'd0, tbl[i].ev});
      cmp($sformatf("tbl%0d_data", i), data_out, tbl[i].ed);
      cmp($sformatf("tbl%0d_outstanding", i), {12'd0, outstanding}, {12'd0, tbl[i].eo});
    end

    // Top-of-address wrap.
    drive("wrap_w", 1'b1, 1'b1, 16'hFFFE, 16'hFFFF);
    drive("wrap_r", 1'b1, 1'b0, 16'hFFFF, 16'h0000);
    idle("wrap_drain", LAT);

    // Reset mid-flight: first read is visible when rst rises and must vanish at once.
    drive("rst_pre_w", 1'b1, 1'b1, 16'h0200, 16'hC0DE);
    for (int i = 0; i < 3; i++) drive("rst_rd", 1'b1, 1'b0, 16'(16'h0202 + 2 * i), 16'h0000);
    drive("rst_pre_idle", 1'b0, 1'b0, 16'h0000, 16'h0000);
    cmp("rst_pre_valid", {15'd0, data_valid}, 16'd1);
    rst = 1'b1;
    exp_d.delete();
    #1;
    check_model("rst_async");
    drive("rst_wr_ignored", 1'b1, 1'b1, 16'h0200, 16'hDEAD);
    rst = 1'b0;
    idle("rst_after", LAT + 2);
    drive("rst_mem_rd", 1'b1, 1'b0, 16'h0200, 16'h0000);
    idle("rst_mem_drain", LAT - 1);
    cmp("rst_mem_kept", data_out, 16'hC0DE);
    idle("rst_mem_tail", 1);

    // Alternating read/idle/write/read pattern.
    for (int i = 0; i < 6; i++) begin
      drive("alt_r", 1'b1, 1'b0, 16'(16'h0204 + 4 * i), 16'h0000);
      drive("alt_i", 1'b0, 1'b0, 16'h0000, 16'h0000);
      drive("alt_w", 1'b1, 1'b1, 16'(16'h0206 + 4 * i), 16'(16'h7000 + i));
      drive("alt_r2", 1'b1, 1'b0, 16'(16'h0206 + 4 * i), 16'h0000);
    end
    idle("alt_drain", LAT);

    // Randomized traffic over the preloaded region.
    for (int i = 0; i < 300; i++) begin
      drive("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            16'(16'h0200 + $urandom_range(0, 63)), 16'($urandom));
    end
    idle("rand_drain", LAT + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
